// File: rtl/mips_cpu_pkg.sv
// mips_cpu_pkg: state encodings shared with mips_cpu_controller and instruction field codes.
package mips_cpu_pkg;
  typedef enum logic [2:0] {
    S_HALT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC1  = 3'd3,
    S_EXEC2  = 3'd4
  } state_t;
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LWR     = 6'h26;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2B;
  localparam logic [5:0] FN_MULT    = 6'h18;
  localparam logic [5:0] FN_DIVU    = 6'h1B;
  localparam logic [4:0] RI_BLTZAL  = 5'h10;
endpackage

// File: rtl/mips_cpu_exec_class.sv
// mips_cpu_exec_class: combinational decode of an instruction into its execute-phase class.
module mips_cpu_exec_class
  import mips_cpu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] fncode,
  input  logic [4:0] regimm,
  output logic       two_exec,
  output logic       mem_exec1,
  output logic       muldiv
);
  logic load;
  logic store;
  assign load      = opcode >= OP_LB && opcode <= OP_LWR;
  assign store     = opcode == OP_SB || opcode == OP_SH || opcode == OP_SW;
  // Link branches (BLTZAL/BGEZAL family) have regimm >= 0x10.
  assign two_exec  = load || (opcode == OP_REGIMM && regimm >= RI_BLTZAL);
  assign mem_exec1 = load || store;
  assign muldiv    = opcode == OP_SPECIAL && fncode >= FN_MULT && fncode <= FN_DIVU;
endmodule

// File: rtl/mips_cpu_state_sequencer.sv
// mips_cpu_state_sequencer: multicycle FETCH/DECODE/EXEC sequencer with retire and stall counters.
module mips_cpu_state_sequencer
  import mips_cpu_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter bit MULDIV_STALL = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             waitrequest,
  input  logic [5:0]       opcode,
  input  logic [5:0]       fncode,
  input  logic [4:0]       regimm,
  input  logic             muldiv_busy,
  input  logic             halt_req,
  output logic [2:0]       state,
  output logic             active,
  output logic             instr_done,
  output logic             stall,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] stall_cnt
);
  state_t           state_q, state_d;
  logic             boot_q, boot_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             two_exec, mem_exec1, muldiv, hold;
  mips_cpu_exec_class u_class (
    .opcode    (opcode),
    .fncode    (fncode),
    .regimm    (regimm),
    .two_exec  (two_exec),
    .mem_exec1 (mem_exec1),
    .muldiv    (muldiv)
  );
  assign hold = (mem_exec1 && waitrequest) || (MULDIV_STALL && muldiv && muldiv_busy);
  // boot_q marks the HALT entered by reset; a HALT reached any other way is absorbing.
  always_comb begin
    state_d    = state_q;
    boot_d     = 1'b0;
    stall      = 1'b0;
    instr_done = 1'b0;
    case (state_q)
      S_HALT:   state_d = boot_q ? S_FETCH : S_HALT;
      S_FETCH: begin
        stall   = waitrequest;
        state_d = waitrequest ? S_FETCH : S_DECODE;
      end
      S_DECODE: state_d = S_EXEC1;
      S_EXEC1: begin
        stall      = hold;
        instr_done = !hold && !two_exec;
        state_d    = hold ? S_EXEC1 : two_exec ? S_EXEC2 : halt_req ? S_HALT : S_FETCH;
      end
      S_EXEC2: begin
        instr_done = 1'b1;
        state_d    = halt_req ? S_HALT : S_FETCH;
      end
      default:  state_d = S_HALT;
    endcase
    retired_d   = retired_q + CNT_W'(instr_done);
    stall_cnt_d = stall_cnt_q + CNT_W'(stall);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_HALT;
      boot_q      <= 1'b1;
      retired_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      boot_q      <= boot_d;
      retired_q   <= retired_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
  assign state       = state_q;
  assign active      = state_q != S_HALT;
  assign retired_cnt = retired_q;
  assign stall_cnt   = stall_cnt_q;
endmodule

// File: tb/tb_mips_cpu_state_sequencer.sv
// tb_mips_cpu_state_sequencer: per-instruction cycle schedules checked against the sequencer.
module tb_mips_cpu_state_sequencer;
  logic        clk, rst_n, waitrequest, muldiv_busy, halt_req;
  logic [5:0]  opcode, fncode;
  logic [4:0]  regimm;
  logic [2:0]  state, m0_state;
  logic        active, instr_done, stall, m0_active, m0_done, m0_stall;
  logic [31:0] retired_cnt, stall_cnt, m0_retired, m0_stall_cnt;
  logic [31:0] ret, stl;
  int          n_vec, n_err;
  logic [5:0]  ops [12] = '{6'h09, 6'h23, 6'h20, 6'h26, 6'h27, 6'h28, 6'h29, 6'h2A, 6'h2B, 6'h01, 6'h00, 6'h3F};
  logic [5:0]  fns [8]  = '{6'h18, 6'h19, 6'h1A, 6'h1B, 6'h08, 6'h21, 6'h17, 6'h1C};

  mips_cpu_state_sequencer #(.CNT_W(32), .MULDIV_STALL(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .waitrequest(waitrequest), .opcode(opcode), .fncode(fncode),
    .regimm(regimm), .muldiv_busy(muldiv_busy), .halt_req(halt_req), .state(state),
    .active(active), .instr_done(instr_done), .stall(stall), .retired_cnt(retired_cnt),
    .stall_cnt(stall_cnt)
  );
  mips_cpu_state_sequencer #(.CNT_W(32), .MULDIV_STALL(1'b0)) dut_nomd (
    .clk(clk), .rst_n(rst_n), .waitrequest(waitrequest), .opcode(opcode), .fncode(fncode),
    .regimm(regimm), .muldiv_busy(muldiv_busy), .halt_req(halt_req), .state(m0_state),
    .active(m0_active), .instr_done(m0_done), .stall(m0_stall), .retired_cnt(m0_retired),
    .stall_cnt(m0_stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  task automatic cyc(input logic [2:0] es, input logic w, mb, hr, xs, xd);
    waitrequest = w; muldiv_busy = mb; halt_req = hr;
    #1;
    check("state", 32'(state), 32'(es));
    check("active", 32'(active), 32'(es != 3'd0));
    check("stall", 32'(stall), 32'(xs));
    check("instr_done", 32'(instr_done), 32'(xd));
    check("retired_cnt", retired_cnt, ret);
    check("stall_cnt", stall_cnt, stl);
    ret += 32'(xd);
    stl += 32'(xs);
    @(negedge clk);
  endtask

  task automatic reset_seq();
    rst_n = 1'b0; waitrequest = rb(); muldiv_busy = rb(); halt_req = rb();
    repeat (3) @(negedge clk);
    #1;
    check("rst_state", 32'(state), 0);
    check("rst_active", 32'(active), 0);
    check("rst_retired", retired_cnt, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_stall", 32'(stall), 0);
    check("rst_done", 32'(instr_done), 0);
    ret = 0; stl = 0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(3'd0, rb(), rb(), rb(), 1'b0, 1'b0);
  endtask

  task automatic run_instr(input logic [5:0] op, fn, input logic [4:0] ri, input int nf, ne, input bit hlt);
    bit two, mem, md, held, fin;
    logic w, mb;
    two = (op inside {[6'h20:6'h26]}) || (op == 6'h01 && ri[4]);
    mem = op inside {[6'h20:6'h26], 6'h28, 6'h29, 6'h2B};
    md  = op == 6'h00 && (fn inside {[6'h18:6'h1B]});
    opcode = op; fncode = fn; regimm = ri;
    for (int i = 0; i < nf; i++) cyc(3'd1, 1'b1, rb(), rb(), 1'b1, 1'b0);
    cyc(3'd1, 1'b0, rb(), rb(), 1'b0, 1'b0);
    cyc(3'd2, rb(), rb(), rb(), 1'b0, 1'b0);
    fin = 0;
    for (int i = 0; !fin; i++) begin
      w    = (i < ne) ? (mem ? 1'b1 : rb()) : (mem ? 1'b0 : rb());
      mb   = (i < ne) ? (md ? 1'b1 : rb()) : (md ? 1'b0 : rb());
      held = (mem && w) || (md && mb);
      if (held) cyc(3'd3, w, mb, rb(), 1'b1, 1'b0);
      else begin
        cyc(3'd3, w, mb, two ? rb() : hlt, 1'b0, !two);
        fin = 1;
      end
    end
    if (two) cyc(3'd4, rb(), rb(), hlt, 1'b0, 1'b1);
  endtask

  task automatic halt_hold();
    repeat (20) cyc(3'd0, rb(), rb(), rb(), 1'b0, 1'b0);
  endtask

  task automatic run_random(input bit allow_halt, output bit hlt);
    hlt = allow_halt && $urandom_range(0, 14) == 0;
    run_instr(ops[$urandom_range(0, 11)], fns[$urandom_range(0, 7)], 5'($urandom),
              ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0, $urandom_range(0, 3), hlt);
  endtask

  initial begin
    bit h;
    clk = 0; rst_n = 0; waitrequest = 0; muldiv_busy = 0; halt_req = 0;
    opcode = 0; fncode = 0; regimm = 0; n_vec = 0; n_err = 0; ret = 0; stl = 0;
    reset_seq();
    run_instr(6'h09, 6'h00, 5'h00, 0, 0, 0);
    check("t1_retired", retired_cnt, 1);
    run_instr(6'h09, 6'h00, 5'h00, 4, 0, 0);
    check("t2_stall_cnt", stall_cnt, 4);
    run_instr(6'h23, 6'h00, 5'h00, 0, 2, 0);
    run_instr(6'h01, 6'h00, 5'h11, 0, 0, 0);
    run_instr(6'h01, 6'h00, 5'h01, 0, 0, 0);
    run_instr(6'h00, 6'h1A, 5'h00, 0, 10, 0);
    check("t5_stall_cnt", stall_cnt, 16);
    run_instr(6'h2B, 6'h00, 5'h00, 0, 3, 1);
    halt_hold();
    reset_seq();
    run_instr(6'h00, 6'h08, 5'h00, 0, 0, 1);
    halt_hold();
    for (int r = 0; r < 6; r++) begin
      reset_seq();
      h = 0;
      for (int k = 0; k < 40 && !h; k++) run_random(1'b1, h);
      if (h) halt_hold();
    end
    reset_seq();
    run_random(1'b0, h);
    run_random(1'b0, h);
    opcode = 6'h23;
    cyc(3'd1, 1'b0, rb(), rb(), 1'b0, 1'b0);
    cyc(3'd2, rb(), rb(), rb(), 1'b0, 1'b0);
    cyc(3'd3, 1'b0, rb(), rb(), 1'b0, 1'b0);
    rst_n = 1'b0; waitrequest = rb();
    #1;
    check("mid_state", 32'(state), 4);
    @(negedge clk);
    #1;
    check("mid_rst_state", 32'(state), 0);
    check("mid_rst_retired", retired_cnt, 0);
    check("mid_rst_stall_cnt", stall_cnt, 0);
    reset_seq();
    opcode = 6'h00; fncode = 6'h1A; muldiv_busy = 1'b1; waitrequest = 1'b0; halt_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("nomd_state", 32'(m0_state), (i < 3) ? i + 1 : i - 2);
      check("nomd_stall", 32'(m0_stall), 0);
      check("md_state", 32'(state), (i < 2) ? i + 1 : 3);
      @(negedge clk);
    end
    #1;
    check("nomd_retired", m0_retired, 1);
    check("nomd_stall_cnt", m0_stall_cnt, 0);
    check("md_stall_cnt", stall_cnt, 3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
